// File: rtl/AluCtrlSig_pkg.sv
`default_nettype none
// ============================================================================
// Package  : AluCtrlSig_pkg
// Purpose  : MIPS opcode/funct encodings and result-scoreboard entry helpers.
// Revision : 1.0
// ============================================================================
package AluCtrlSig_pkg;

  localparam int OPC_W  = 6;
  localparam int SCB_DW = 32;

  typedef enum logic [OPC_W-1:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_XOR = 6'h26,
    FN_NOR = 6'h27,
    FN_SLT = 6'h2A
  } funct_e;

  // Default-width queue entry; the scoreboard packs {exp_val, opcode} at its own DW.
  typedef struct packed {
    logic [SCB_DW-1:0] exp_val;
    logic [OPC_W-1:0]  opcode;
  } scb_entry_t;

  // Ops whose result the scoreboard predicts and queues.
  function automatic logic scb_op_supported(input logic [OPC_W-1:0] opcode,
                                            input logic [5:0]       funct);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_BEQ, OP_BNE, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic scb_op_memory(input logic [OPC_W-1:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : scb_fifo
// Purpose  : Synchronous FIFO with flush; a pop frees space for a same-cycle push.
// Revision : 1.0
// ============================================================================
module scb_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          w_do_push, w_do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    w_do_pop  = pop & ~empty;
    w_do_push = push & (~full | w_do_pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/mips_result_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : mips_result_scoreboard
// Purpose  : Predicts MIPS results at issue, checks them in order at writeback.
// Revision : 1.0
// ============================================================================
module mips_result_scoreboard
  import AluCtrlSig_pkg::*;
#(
  parameter int DW       = 32,
  parameter int QDEPTH   = 8,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [31:0]      issue_inst,
  input  logic [DW-1:0]    issue_pc,
  input  logic [DW-1:0]    issue_rs_val,
  input  logic [DW-1:0]    issue_rt_val,
  input  logic             wb_valid,
  input  logic [DW-1:0]    wb_data,
  input  logic             flush,
  output logic             op_done,
  output logic             mismatch,
  output logic             timeout,
  output logic             illegal,
  output logic [DW-1:0]    exp_data,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             q_full,
  output logic             q_empty,
  output logic             overflow
);

  localparam int ENTRY_W = DW + OPC_W;
  localparam int AGE_W   = $clog2(MAX_WAIT + 1);

  logic [OPC_W-1:0]   w_opcode;
  logic [5:0]         w_funct;
  logic [DW-1:0]      w_sext, w_pc4, w_exp;
  logic               w_supported, w_push, w_pop, w_cmp, w_timeout;
  logic [ENTRY_W-1:0] w_head;
  logic [DW-1:0]      w_head_exp;
  logic [OPC_W-1:0]   w_unused_head_opc;

  logic             op_done_q, op_done_d, mismatch_q, mismatch_d;
  logic             timeout_q, timeout_d, illegal_q, illegal_d;
  logic             overflow_q, overflow_d;
  logic [DW-1:0]    exp_data_q, exp_data_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [AGE_W-1:0] age_q, age_d;

  assign w_opcode          = issue_inst[31:26];
  assign w_funct           = issue_inst[5:0];
  assign w_sext            = {{(DW-16){issue_inst[15]}}, issue_inst[15:0]};
  assign w_pc4             = issue_pc + DW'(4);
  assign w_supported       = scb_op_supported(w_opcode, w_funct);
  assign w_head_exp        = w_head[ENTRY_W-1:OPC_W];
  assign w_unused_head_opc = w_head[OPC_W-1:0];

  always_comb begin
    w_exp = '0;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD:  w_exp = issue_rs_val + issue_rt_val;
          FN_SUB:  w_exp = issue_rs_val - issue_rt_val;
          FN_AND:  w_exp = issue_rs_val & issue_rt_val;
          FN_OR:   w_exp = issue_rs_val | issue_rt_val;
          FN_XOR:  w_exp = issue_rs_val ^ issue_rt_val;
          FN_NOR:  w_exp = ~(issue_rs_val | issue_rt_val);
          FN_SLT:  w_exp = {{(DW-1){1'b0}}, $signed(issue_rs_val) < $signed(issue_rt_val)};
          default: w_exp = '0;
        endcase
      end
      OP_ADDI: w_exp = issue_rs_val + w_sext;
      OP_BEQ:  w_exp = (issue_rs_val == issue_rt_val) ? w_pc4 + (w_sext << 2) : w_pc4;
      OP_BNE:  w_exp = (issue_rs_val != issue_rt_val) ? w_pc4 + (w_sext << 2) : w_pc4;
      OP_J:    w_exp = {w_pc4[DW-1:28], issue_inst[25:0], 2'b00};
      default: w_exp = '0;
    endcase
  end

  scb_fifo #(
    .W     (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (flush),
    .din   ({w_exp, w_opcode}),
    .dout  (w_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // A writeback in the timeout cycle is compared instead of timing out.
  always_comb begin
    w_push     = issue_valid & w_supported & ~flush;
    w_cmp      = wb_valid & ~flush & ~q_empty;
    w_timeout  = ~flush & ~wb_valid & ~q_empty & (age_q == AGE_W'(MAX_WAIT));
    w_pop      = w_cmp | w_timeout;
    illegal_d  = issue_valid & ~w_supported & ~scb_op_memory(w_opcode);
    op_done_d  = w_cmp & (w_head_exp == wb_data);
    mismatch_d = wb_valid & ~flush & (q_empty | (w_head_exp != wb_data));
    timeout_d  = w_timeout;
    exp_data_d = w_pop ? w_head_exp : exp_data_q;
    overflow_d = overflow_q | (w_push & q_full & ~w_pop);
    pass_cnt_d = (op_done_d && (pass_cnt_q != '1)) ? pass_cnt_q + 1'b1 : pass_cnt_q;
    fail_cnt_d = ((mismatch_d || timeout_d) && (fail_cnt_q != '1)) ? fail_cnt_q + 1'b1
                                                                   : fail_cnt_q;
    if (flush || w_pop || q_empty) age_d = '0;
    else                           age_d = age_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_done_q  <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
      illegal_q  <= 1'b0;
      overflow_q <= 1'b0;
      exp_data_q <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      age_q      <= '0;
    end else begin
      op_done_q  <= op_done_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
      illegal_q  <= illegal_d;
      overflow_q <= overflow_d;
      exp_data_q <= exp_data_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      age_q      <= age_d;
    end
  end

  assign op_done  = op_done_q;
  assign mismatch = mismatch_q;
  assign timeout  = timeout_q;
  assign illegal  = illegal_q;
  assign overflow = overflow_q;
  assign exp_data = exp_data_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_result_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_result_scoreboard
// Purpose  : Directed vector table plus multi-cycle sequences for the scoreboard.
// Revision : 1.0
// ============================================================================
module tb_mips_result_scoreboard;

  localparam int DW = 32, QDEPTH = 8, MAX_WAIT = 16, CNT_W = 16;

  logic             clk, reset, issue_valid, wb_valid, flush;
  logic [31:0]      issue_inst;
  logic [DW-1:0]    issue_pc, issue_rs_val, issue_rt_val, wb_data;
  logic             op_done, mismatch, timeout, illegal, q_full, q_empty, overflow;
  logic [DW-1:0]    exp_data;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  mips_result_scoreboard #(
    .DW(DW), .QDEPTH(QDEPTH), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_inst(issue_inst),
    .issue_pc(issue_pc), .issue_rs_val(issue_rs_val), .issue_rt_val(issue_rt_val),
    .wb_valid(wb_valid), .wb_data(wb_data), .flush(flush),
    .op_done(op_done), .mismatch(mismatch), .timeout(timeout), .illegal(illegal),
    .exp_data(exp_data), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .q_full(q_full), .q_empty(q_empty), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int exp_pass = 0, exp_fail = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc, rs, rt, wb;
    int          gap;
    logic        ok;
    logic [31:0] expv;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [25:0] addr);
    return {6'h02, addr};
  endfunction

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt);
    issue_valid  = 1'b1;
    issue_inst   = inst;
    issue_pc     = pc;
    issue_rs_val = rs;
    issue_rt_val = rt;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pass_cnt"}, 64'(pass_cnt), 64'(exp_pass));
    check({tag, "_fail_cnt"}, 64'(fail_cnt), 64'(exp_fail));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0]  = '{rtype(6'h20), 32'h0, 32'd5, 32'd7, 32'd12, 2, 1'b1, 32'd12};
    vecs[1]  = '{rtype(6'h22), 32'h0, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 1'b1, 32'hFFFF_FFFE};
    vecs[2]  = '{rtype(6'h2A), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1'b0, 32'd1};
    vecs[3]  = '{itype(6'h04, 16'h0003), 32'h100, 32'd4, 32'd4, 32'h110, 0, 1'b1, 32'h110};
    vecs[4]  = '{itype(6'h05, 16'h0003), 32'h100, 32'd4, 32'd4, 32'h104, 0, 1'b1, 32'h104};
    vecs[5]  = '{rtype(6'h24), 32'h0, 32'hF0F0, 32'hFF00, 32'hF000, 1, 1'b1, 32'hF000};
    vecs[6]  = '{rtype(6'h25), 32'h0, 32'hF0F0, 32'h0F00, 32'hFFF0, 0, 1'b1, 32'hFFF0};
    vecs[7]  = '{rtype(6'h27), 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFF};
    vecs[8]  = '{rtype(6'h26), 32'h0, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 0, 1'b1, 32'h5A5A_5A5A};
    vecs[9]  = '{itype(6'h08, 16'hFFFF), 32'h0, 32'd10, 32'd0, 32'd9, 0, 1'b1, 32'd9};
    vecs[10] = '{jtype(26'h123), 32'h4000_0000, 32'd0, 32'd0, 32'h4000_048C, 0, 1'b1, 32'h4000_048C};
    vecs[11] = '{rtype(6'h2A), 32'h0, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 1'b1, 32'd0};
    vecs[12] = '{rtype(6'h20), 32'h0, 32'hFFFF_FFFF, 32'd2, 32'd1, 0, 1'b1, 32'd1};
    vecs[13] = '{itype(6'h04, 16'hFFFE), 32'h200, 32'd9, 32'd9, 32'h1FC, 0, 1'b1, 32'h1FC};
    vecs[14] = '{itype(6'h05, 16'h0010), 32'h100, 32'd1, 32'd2, 32'h144, 0, 1'b1, 32'h144};

    issue_valid = 0; issue_inst = 0; issue_pc = 0; issue_rs_val = 0; issue_rt_val = 0;
    wb_valid = 0; wb_data = 0; flush = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_op_done", 64'(op_done), 0);
    check("rst_mismatch", 64'(mismatch), 0);
    check("rst_timeout", 64'(timeout), 0);
    check("rst_illegal", 64'(illegal), 0);
    check("rst_exp_data", 64'(exp_data), 0);
    check("rst_q_full", 64'(q_full), 0);
    check("rst_q_empty", 64'(q_empty), 1);
    check("rst_overflow", 64'(overflow), 0);
    check_counts("rst");
    reset = 1'b0;
    step();

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].inst, vecs[i].pc, vecs[i].rs, vecs[i].rt);
      step();
      issue_valid = 1'b0;
      repeat (vecs[i].gap) step();
      wb_valid = 1'b1;
      wb_data  = vecs[i].wb;
      step();
      wb_valid = 1'b0;
      if (vecs[i].ok) exp_pass++; else exp_fail++;
      check($sformatf("vec%0d_op_done", i), 64'(op_done), 64'(vecs[i].ok));
      check($sformatf("vec%0d_mismatch", i), 64'(mismatch), 64'(!vecs[i].ok));
      check($sformatf("vec%0d_exp_data", i), 64'(exp_data), 64'(vecs[i].expv));
      check($sformatf("vec%0d_q_empty", i), 64'(q_empty), 1);
      check_counts($sformatf("vec%0d", i));
    end

    // Fill to full, then push and pop in the same cycle: accepted, no overflow.
    for (int k = 0; k < 8; k++) begin
      issue(itype(6'h08, 16'h0001), 32'h0, 32'(k), 32'h0);
      step();
    end
    issue_valid = 1'b0;
    check("fill_q_full", 64'(q_full), 1);
    check("fill_overflow", 64'(overflow), 0);
    issue(itype(6'h08, 16'h0001), 32'h0, 32'd100, 32'h0);
    wb_valid = 1'b1;
    wb_data  = 32'd1;
    step();
    issue_valid = 1'b0;
    exp_pass++;
    check("pushpop_op_done", 64'(op_done), 1);
    check("pushpop_q_full", 64'(q_full), 1);
    check("pushpop_overflow", 64'(overflow), 0);
    for (int j = 0; j < 8; j++) begin
      wb_data = (j < 7) ? 32'(j + 2) : 32'd101;
      step();
      check($sformatf("drain1_%0d_op_done", j), 64'(op_done), 1);
    end
    wb_valid = 1'b0;
    exp_pass += 8;
    check("drain1_q_empty", 64'(q_empty), 1);
    check_counts("drain1");

    // Nine issues into an eight-deep queue: the ninth is dropped.
    for (int k = 0; k < 9; k++) begin
      issue(itype(6'h08, 16'h0001), 32'h0, 32'(k), 32'h0);
      step();
      if (k == 7) begin
        check("ovf_full_at_8", 64'(q_full), 1);
        check("ovf_not_yet", 64'(overflow), 0);
      end
    end
    issue_valid = 1'b0;
    check("ovf_set", 64'(overflow), 1);
    wb_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wb_data = 32'(k + 1);
      step();
      check($sformatf("drain2_%0d_op_done", k), 64'(op_done), 1);
    end
    wb_valid = 1'b0;
    exp_pass += 8;
    check("drain2_q_empty", 64'(q_empty), 1);
    check("drain2_overflow_sticky", 64'(overflow), 1);
    check_counts("drain2");

    // Withheld writeback times out MAX_WAIT+1 cycles after issue.
    issue(rtype(6'h20), 32'h0, 32'd20, 32'd22);
    step();
    issue_valid = 1'b0;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (timeout) begin
        n = c;
        break;
      end
    end
    exp_fail++;
    check("timeout_latency", 64'(n), 64'(MAX_WAIT + 1));
    check("timeout_q_empty", 64'(q_empty), 1);
    check("timeout_exp_data", 64'(exp_data), 42);
    check_counts("timeout");
    wb_valid = 1'b1;
    wb_data  = 32'h55;
    step();
    wb_valid = 1'b0;
    exp_fail++;
    check("emptywb_mismatch", 64'(mismatch), 1);
    check("emptywb_exp_data", 64'(exp_data), 42);
    check_counts("emptywb");

    // Issue into an empty queue alongside a writeback: mismatch, entry still queued.
    issue(rtype(6'h20), 32'h0, 32'd1, 32'd1);
    wb_valid = 1'b1;
    wb_data  = 32'd2;
    step();
    issue_valid = 1'b0;
    exp_fail++;
    check("sameiss_mismatch", 64'(mismatch), 1);
    check("sameiss_op_done", 64'(op_done), 0);
    check("sameiss_q_empty", 64'(q_empty), 0);
    step();
    wb_valid = 1'b0;
    exp_pass++;
    check("sameiss2_op_done", 64'(op_done), 1);
    check("sameiss2_exp_data", 64'(exp_data), 2);
    check("sameiss2_q_empty", 64'(q_empty), 1);
    check_counts("sameiss");

    // Flush suppresses the same-cycle compare and push.
    issue(rtype(6'h20), 32'h0, 32'd3, 32'd3);
    step();
    step();
    flush = 1'b1;
    wb_valid = 1'b1;
    wb_data  = 32'h77;
    step();
    flush = 1'b0;
    wb_valid = 1'b0;
    issue_valid = 1'b0;
    check("flush_op_done", 64'(op_done), 0);
    check("flush_mismatch", 64'(mismatch), 0);
    check("flush_q_empty", 64'(q_empty), 1);
    check("flush_overflow_kept", 64'(overflow), 1);
    check_counts("flush");

    // Asynchronous reset with entries queued.
    for (int k = 0; k < 3; k++) begin
      issue(rtype(6'h20), 32'h0, 32'(k), 32'd1);
      step();
    end
    issue_valid = 1'b0;
    check("prerst_q_empty", 64'(q_empty), 0);
    #2 reset = 1'b1;
    #1;
    exp_pass = 0;
    exp_fail = 0;
    check("midrst_q_empty", 64'(q_empty), 1);
    check("midrst_overflow", 64'(overflow), 0);
    check("midrst_exp_data", 64'(exp_data), 0);
    check_counts("midrst");
    @(negedge clk);
    reset = 1'b0;
    step();

    // Unknown funct flags illegal; LW is silently ignored.
    issue(rtype(6'h3F), 32'h0, 32'd1, 32'd1);
    step();
    issue_valid = 1'b0;
    check("illegal_pulse", 64'(illegal), 1);
    check("illegal_q_empty", 64'(q_empty), 1);
    step();
    check("illegal_clear", 64'(illegal), 0);
    issue(itype(6'h23, 16'h0004), 32'h0, 32'd1, 32'd1);
    step();
    issue_valid = 1'b0;
    check("lw_no_illegal", 64'(illegal), 0);
    check("lw_q_empty", 64'(q_empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
